// File: rtl/vliw_wb_pkg.sv
// Shared types and default sizing for the VLIW writeback arbiter.
// Optional build macro used by the arbiter: WB_R0_DROP_EN.
package vliw_wb_pkg;

    localparam int WB_NUM_REQ   = 8;
    localparam int WB_NUM_PORTS = 2;
    localparam int REG_ADDR_W   = 5;
    localparam int REG_DATA_W   = 32;

    // Requester slot assignment on the writeback bus
    localparam int REQ_ADD0   = 0;
    localparam int REQ_ADD1   = 1;
    localparam int REQ_MUL_HI = 2;
    localparam int REQ_MUL_LO = 3;
    localparam int REQ_FADD0  = 4;
    localparam int REQ_FADD1  = 5;
    localparam int REQ_FMUL   = 6;
    localparam int REQ_LOGIC  = 7;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry writeback FIFO; head is always visible on head_o.
// Push is ignored when full and pop is ignored when empty.
module wb_fifo2
    import vliw_wb_pkg::*;
#(
    parameter type entry_t = wb_entry_t
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  entry_t     din_i,
    input  logic       pop_i,
    output entry_t     head_o,
    output logic [1:0] count_o
);

    entry_t     mem_q [2];
    logic [1:0] count_q;
    logic       push_ok;
    logic       pop_ok;

    assign push_ok = push_i && (count_q < 2'd2);
    assign pop_ok  = pop_i && (count_q != 2'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q  <= '0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (count_q == 2'd0) mem_q[0] <= din_i;
                    else                 mem_q[1] <= din_i;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    mem_q[0] <= mem_q[1];
                    count_q  <= count_q - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new entry lands behind whatever remains
                    if (count_q == 2'd1) begin
                        mem_q[0] <= din_i;
                    end else begin
                        mem_q[0] <= mem_q[1];
                        mem_q[1] <= din_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_o  = mem_q[0];
    assign count_o = count_q;

endmodule

// File: rtl/vliw_wb_arbiter.sv
// Round-robin writeback arbiter: NUM_REQ two-deep FIFOs drained onto NUM_PORTS write ports.
// Build macro WB_R0_DROP_EN: heads targeting r0 are discarded without using a port.
module vliw_wb_arbiter
    import vliw_wb_pkg::*;
#(
    parameter int NUM_REQ   = WB_NUM_REQ,
    parameter int NUM_PORTS = WB_NUM_PORTS,
    parameter int DATA_W    = REG_DATA_W,
    parameter int ADDR_W    = REG_ADDR_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_PORTS-1:0]        wr_en,
    output logic [NUM_PORTS*ADDR_W-1:0] wr_addr,
    output logic [NUM_PORTS*DATA_W-1:0] wr_data,
    output logic                        busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t               head [NUM_REQ];
    entry_t               din  [NUM_REQ];
    logic [1:0]           count [NUM_REQ];
    logic [NUM_REQ-1:0]   push;
    logic [NUM_REQ-1:0]   pop;
    logic [NUM_REQ-1:0]   nonempty;

    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_PORTS-1:0] wr_en_q, wr_en_d;
    entry_t               wr_entry_d [NUM_PORTS];
    logic [ADDR_W-1:0]    wr_addr_q [NUM_PORTS];
    logic [DATA_W-1:0]    wr_data_q [NUM_PORTS];

    int                   n_gnt;
    int                   idx;
    int                   last_idx;
    logic                 clash;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
        assign din[i]       = '{addr: req_addr[i*ADDR_W +: ADDR_W],
                                data: req_data[i*DATA_W +: DATA_W]};
        assign req_ready[i] = rst_n && (count[i] < 2'd2);
        assign push[i]      = req_valid[i] && req_ready[i];
        assign nonempty[i]  = (count[i] != 2'd0);

        wb_fifo2 #(.entry_t(entry_t)) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .push_i  (push[i]),
            .din_i   (din[i]),
            .pop_i   (pop[i]),
            .head_o  (head[i]),
            .count_o (count[i])
        );
    end

    // Scan from rr_ptr; a head whose address is already granted this cycle waits
    always_comb begin
        pop      = '0;
        wr_en_d  = '0;
        n_gnt    = 0;
        idx      = 0;
        last_idx = 0;
        clash    = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) wr_entry_d[p] = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i == idx && nonempty[i]) begin
                    clash = 1'b0;
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        if (wr_en_d[p] && wr_entry_d[p].addr == head[i].addr) clash = 1'b1;
                    end
`ifdef WB_R0_DROP_EN
                    if (head[i].addr == '0) pop[i] = 1'b1;
                    else
`endif
                    if (!clash && n_gnt < NUM_PORTS) begin
                        for (int p = 0; p < NUM_PORTS; p++) begin
                            if (p == n_gnt) begin
                                wr_en_d[p]    = 1'b1;
                                wr_entry_d[p] = head[i];
                            end
                        end
                        pop[i]   = 1'b1;
                        last_idx = i;
                        n_gnt    = n_gnt + 1;
                    end
                end
            end
        end
        if (n_gnt == 0)                  rr_ptr_d = rr_ptr_q;
        else if (last_idx == NUM_REQ - 1) rr_ptr_d = '0;
        else                              rr_ptr_d = PTR_W'(last_idx + 1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            wr_en_q  <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                wr_addr_q[p] <= '0;
                wr_data_q[p] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wr_en_q  <= wr_en_d;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (wr_en_d[p]) begin
                    wr_addr_q[p] <= wr_entry_d[p].addr;
                    wr_data_q[p] <= wr_entry_d[p].data;
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign wr_addr[p*ADDR_W +: ADDR_W] = wr_addr_q[p];
        assign wr_data[p*DATA_W +: DATA_W] = wr_data_q[p];
    end

    assign wr_en = wr_en_q;
    assign busy  = (|nonempty) || (|wr_en_q);

endmodule

// File: tb/tb_vliw_wb_arbiter.sv
// Directed self-checking bench for vliw_wb_arbiter (default 8 requesters, 2 ports).
// Honours WB_R0_DROP_EN when the design is built with it.
module tb_vliw_wb_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   req_valid;
    logic [39:0]  req_addr;
    logic [255:0] req_data;
    logic [7:0]   req_ready;
    logic [1:0]   wr_en;
    logic [9:0]   wr_addr;
    logic [63:0]  wr_data;
    logic         busy;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    vliw_wb_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_req(input int u, input logic [4:0] a, input logic [31:0] d);
        req_valid[u]        = 1'b1;
        req_addr[u*5 +: 5]  = a;
        req_data[u*32 +: 32] = d;
    endtask

    // Stream bookkeeping for units 0, 1 and 3 (addr = 10+unit, data = {unit, seq})
    int   sent [4];
    int   expq [4];
    logic acc  [4];
    int   ul   [3] = '{0, 1, 3};
    logic r3_low;

    task automatic mon3();
        int u;
        for (int p = 0; p < 2; p++) begin
            if (wr_en[p]) begin
                u = int'(wr_data[p*32+8 +: 8]);
                if (u == 0 || u == 1 || u == 3) begin
                    chk("stream_addr", 32'(wr_addr[p*5 +: 5]), 32'(10 + u));
                    chk("stream_order", 32'(wr_data[p*32 +: 8]), 32'(expq[u]));
                    expq[u]++;
                end else begin
                    chk("stream_unit_id", 32'(u), 32'hFF);
                end
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        r3_low    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sent[i] = 0;
            expq[i] = 0;
        end

        // Reset state
        tick();
        tick();
        chk("rst_wr_en", 32'(wr_en), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_wr_addr", 32'(wr_addr), 32'h0);
        chk("rst_wr_data_lo", wr_data[31:0], 32'h0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", 32'(req_ready), 32'hFF);

        // All eight units at once, addrs 1..8: pairs (0,1),(2,3),(4,5),(6,7)
        for (int i = 0; i < 8; i++) set_req(i, 5'(i + 1), 32'h100 + 32'(i));
        tick();
        req_valid = '0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("pair_wr_en", 32'(wr_en), 32'h3);
            chk("pair_p0_addr", 32'(wr_addr[4:0]), 32'(2*c + 1));
            chk("pair_p1_addr", 32'(wr_addr[9:5]), 32'(2*c + 2));
            chk("pair_p0_data", wr_data[31:0], 32'h100 + 32'(2*c));
            chk("pair_p1_data", wr_data[63:32], 32'h100 + 32'(2*c + 1));
        end
        chk("pair_rr_ptr", 32'(dut.rr_ptr_q), 32'h0);
        tick();
        chk("pair_idle_wr_en", 32'(wr_en), 32'h0);
        chk("pair_idle_busy", 32'(busy), 32'h0);

        // Units 1 and 2 both target r7 with rr_ptr at 0
        set_req(1, 5'd7, 32'hA1);
        set_req(2, 5'd7, 32'hA2);
        tick();
        req_valid = '0;
        tick();
        chk("waw_n_wr_en", 32'(wr_en), 32'h1);
        chk("waw_n_addr", 32'(wr_addr[4:0]), 32'd7);
        chk("waw_n_data", wr_data[31:0], 32'hA1);
        tick();
        chk("waw_n1_wr_en", 32'(wr_en), 32'h1);
        chk("waw_n1_addr", 32'(wr_addr[4:0]), 32'd7);
        chk("waw_n1_data", wr_data[31:0], 32'hA2);
        tick();
        chk("waw_idle_wr_en", 32'(wr_en), 32'h0);

        // Single result from unit 0
        set_req(0, 5'd5, 32'hDEADBEEF);
        tick();
        req_valid = '0;
        chk("single_accept_wr_en", 32'(wr_en), 32'h0);
        chk("single_accept_busy", 32'(busy), 32'h1);
        tick();
        chk("single_wr_en", 32'(wr_en), 32'h1);
        chk("single_addr", 32'(wr_addr[4:0]), 32'd5);
        chk("single_data", wr_data[31:0], 32'hDEADBEEF);
        chk("single_busy", 32'(busy), 32'h1);
        tick();
        chk("single_done_wr_en", 32'(wr_en), 32'h0);
        chk("single_done_busy", 32'(busy), 32'h0);
        chk("single_hold_addr", 32'(wr_addr[4:0]), 32'd5);
        chk("single_hold_data", wr_data[31:0], 32'hDEADBEEF);

        // Units 0, 1 and 3 streaming every cycle; demand exceeds the two ports
        for (int c = 0; c < 12; c++) begin
            for (int j = 0; j < 3; j++) begin
                set_req(ul[j], 5'(10 + ul[j]), {16'h0, 8'(ul[j]), 8'(sent[ul[j]])});
                acc[ul[j]] = req_ready[ul[j]];
            end
            if (!req_ready[3]) r3_low = 1'b1;
            tick();
            for (int j = 0; j < 3; j++) if (acc[ul[j]]) sent[ul[j]]++;
            mon3();
        end
        req_valid = '0;
        for (int c = 0; c < 8; c++) begin
            tick();
            mon3();
        end
        chk("stream_ready3_dropped", 32'(r3_low), 32'h1);
        chk("stream_count_u0", 32'(expq[0]), 32'(sent[0]));
        chk("stream_count_u1", 32'(expq[1]), 32'(sent[1]));
        chk("stream_count_u3", 32'(expq[3]), 32'(sent[3]));
        chk("stream_idle_busy", 32'(busy), 32'h0);

        // Mid-operation reset with three FIFOs occupied
        set_req(2, 5'd20, 32'h22);
        set_req(5, 5'd21, 32'h55);
        set_req(6, 5'd22, 32'h66);
        tick();
        chk("prerst_busy", 32'(busy), 32'h1);
        req_valid = '0;
        rst_n     = 1'b0;
        #1;
        chk("midrst_ready", 32'(req_ready), 32'h0);
        tick();
        chk("midrst_wr_en", 32'(wr_en), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_wr_addr", 32'(wr_addr), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("midrst_rel_ready", 32'(req_ready), 32'hFF);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("postrst_wr_en", 32'(wr_en), 32'h0);
            chk("postrst_busy", 32'(busy), 32'h0);
        end

        // Write to r0 from unit 4
        set_req(4, 5'd0, 32'h1234);
        tick();
        req_valid = '0;
        chk("r0_accept_busy", 32'(busy), 32'h1);
        tick();
`ifdef WB_R0_DROP_EN
        chk("r0_drop_wr_en", 32'(wr_en), 32'h0);
        chk("r0_drop_busy", 32'(busy), 32'h0);
        tick();
        chk("r0_drop_later_wr_en", 32'(wr_en), 32'h0);
`else
        chk("r0_wr_en", 32'(wr_en), 32'h1);
        chk("r0_addr", 32'(wr_addr[4:0]), 32'h0);
        chk("r0_data", wr_data[31:0], 32'h1234);
        tick();
        chk("r0_done_wr_en", 32'(wr_en), 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
